// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, IF/ID capture, stall, branch flush.
// Optional halt-on-all-ones feature enabled by defining FETCH_HALT_EN.
module instruction_fetch_ctrl #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inStall,
   input  logic              inBranchTaken,
   input  logic [ADDR_W-1:0] inBranchTarget,
   input  logic [DATA_W-1:0] inInstruction,
   output logic [ADDR_W-1:0] outPcAddr,
   output logic [DATA_W-1:0] outInstructionIfId,
   output logic [ADDR_W-1:0] outPcPlusOneIfId,
   output logic              outValid,
   output logic              outHalted,
   output logic [CNT_W-1:0]  outFetchCount
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ppo_q, ppo_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W-1:0] pc_inc;
   logic              halt_word;

   assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_HALT_EN
   assign halt_word = (inInstruction == {DATA_W{1'b1}});
   assign outHalted = halted_q;
`else
   assign halt_word = 1'b0;
   assign outHalted = 1'b0;
`endif

   // Priority: branch, halted, stall, halt word, normal fetch.
   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      ppo_d    = ppo_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      count_d  = count_q;
      if (inBranchTaken) begin
         pc_d     = inBranchTarget;
         instr_d  = '0;
         valid_d  = 1'b0;
         halted_d = 1'b0;
      end else if (halted_q) begin
         instr_d = '0;
         valid_d = 1'b0;
      end else if (inStall) begin
         pc_d = pc_q;
      end else if (halt_word) begin
         instr_d  = inInstruction;
         ppo_d    = pc_inc;
         valid_d  = 1'b0;
         halted_d = 1'b1;
      end else begin
         instr_d = inInstruction;
         ppo_d   = pc_inc;
         valid_d = 1'b1;
         pc_d    = pc_inc;
         if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q     <= '0;
         instr_q  <= '0;
         ppo_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         ppo_q    <= ppo_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   assign outPcAddr          = pc_q;
   assign outInstructionIfId = instr_q;
   assign outPcPlusOneIfId   = ppo_q;
   assign outValid           = valid_q;
   assign outFetchCount      = count_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench for instruction_fetch_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural fetch model.
module tb_instruction_fetch_ctrl;

`ifdef FETCH_HALT_EN
   localparam bit HaltEn = 1'b1;
`else
   localparam bit HaltEn = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        inStall;
   logic        inBranchTaken;
   logic [3:0]  inBranchTarget;
   logic [31:0] inInstruction;
   logic [3:0]  outPcAddr;
   logic [31:0] outInstructionIfId;
   logic [3:0]  outPcPlusOneIfId;
   logic        outValid;
   logic        outHalted;
   logic [15:0] outFetchCount;

   logic [31:0] mem [16];

   instruction_fetch_ctrl #(
      .ADDR_W (4),
      .DATA_W (32),
      .CNT_W  (16)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .inStall            (inStall),
      .inBranchTaken      (inBranchTaken),
      .inBranchTarget     (inBranchTarget),
      .inInstruction      (inInstruction),
      .outPcAddr          (outPcAddr),
      .outInstructionIfId (outInstructionIfId),
      .outPcPlusOneIfId   (outPcPlusOneIfId),
      .outValid           (outValid),
      .outHalted          (outHalted),
      .outFetchCount      (outFetchCount)
   );

   assign inInstruction = mem[outPcAddr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   int          m_pc;
   logic [31:0] m_instr;
   int          m_ppo;
   bit          m_valid;
   bit          m_halted;
   int          m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [31:0] word;
      word = mem[m_pc];
      if (!reset) begin
         m_pc = 0; m_instr = 0; m_ppo = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
      end else if (inBranchTaken) begin
         m_pc = int'(inBranchTarget); m_instr = 0; m_valid = 0; m_halted = 0;
      end else if (m_halted) begin
         m_instr = 0; m_valid = 0;
      end else if (inStall) begin
         // everything held
      end else if (HaltEn && word == 32'hFFFF_FFFF) begin
         m_instr = word; m_ppo = (m_pc + 1) % 16; m_valid = 0; m_halted = 1;
      end else begin
         m_instr = word;
         m_ppo   = (m_pc + 1) % 16;
         m_valid = 1;
         m_pc    = (m_pc + 1) % 16;
         m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".pc"}, 64'(outPcAddr), 64'(m_pc));
      chk({tag, ".instr"}, 64'(outInstructionIfId), 64'(m_instr));
      chk({tag, ".valid"}, 64'(outValid), 64'(m_valid));
      chk({tag, ".halted"}, 64'(outHalted), 64'(m_halted));
      chk({tag, ".count"}, 64'(outFetchCount), 64'(m_cnt));
      if (m_valid) chk({tag, ".ppo"}, 64'(outPcPlusOneIfId), 64'(m_ppo));
   endtask

   // Apply inputs, advance the model and the DUT by one edge, compare after the edge.
   task automatic tick(input bit rst_n, input bit st, input bit br, input logic [3:0] tgt,
                       input string tag);
      reset = rst_n; inStall = st; inBranchTaken = br; inBranchTarget = tgt;
      #1;
      model_edge();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic init_mem();
      for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[0] = 32'h1001_0001;
      mem[1] = 32'h8CC3_0000;
   endtask

   typedef struct {
      bit          rst_n;
      bit          st;
      bit          br;
      logic [3:0]  tgt;
      logic [3:0]  pc;
      logic        v;
      logic [31:0] ins;
      logic [3:0]  ppo;
      int          cnt;
   } vec_t;

   vec_t tbl [13];

   initial begin
      reset = 1'b0; inStall = 1'b0; inBranchTaken = 1'b0; inBranchTarget = 4'd0;
      init_mem();

      tbl[0]  = '{0, 0, 0, 4'd0, 4'd0,  0, 32'h0,         4'd0,  0};
      tbl[1]  = '{0, 0, 0, 4'd0, 4'd0,  0, 32'h0,         4'd0,  0};
      tbl[2]  = '{0, 0, 0, 4'd0, 4'd0,  0, 32'h0,         4'd0,  0};
      tbl[3]  = '{1, 0, 0, 4'd0, 4'd1,  1, 32'h1001_0001, 4'd1,  1};
      tbl[4]  = '{1, 0, 0, 4'd0, 4'd2,  1, 32'h8CC3_0000, 4'd2,  2};
      tbl[5]  = '{1, 1, 0, 4'd0, 4'd2,  1, 32'h8CC3_0000, 4'd2,  2};
      tbl[6]  = '{1, 0, 0, 4'd0, 4'd3,  1, 32'hA000_0002, 4'd3,  3};
      tbl[7]  = '{1, 0, 1, 4'd9, 4'd9,  0, 32'h0,         4'd0,  3};
      tbl[8]  = '{1, 0, 0, 4'd0, 4'd10, 1, 32'hA000_0009, 4'd10, 4};
      tbl[9]  = '{1, 1, 1, 4'd2, 4'd2,  0, 32'h0,         4'd0,  4};
      tbl[10] = '{1, 0, 0, 4'd0, 4'd3,  1, 32'hA000_0002, 4'd3,  5};
      tbl[11] = '{0, 1, 0, 4'd0, 4'd0,  0, 32'h0,         4'd0,  0};
      tbl[12] = '{1, 0, 0, 4'd0, 4'd1,  1, 32'h1001_0001, 4'd1,  1};

      for (int r = 0; r < 13; r++) begin
         tick(tbl[r].rst_n, tbl[r].st, tbl[r].br, tbl[r].tgt, $sformatf("row%0d", r));
         chk($sformatf("tbl%0d.pc", r), 64'(outPcAddr), 64'(tbl[r].pc));
         chk($sformatf("tbl%0d.valid", r), 64'(outValid), 64'(tbl[r].v));
         chk($sformatf("tbl%0d.instr", r), 64'(outInstructionIfId), 64'(tbl[r].ins));
         chk($sformatf("tbl%0d.count", r), 64'(outFetchCount), 64'(tbl[r].cnt));
         if (tbl[r].v || !tbl[r].rst_n)
            chk($sformatf("tbl%0d.ppo", r), 64'(outPcPlusOneIfId), 64'(tbl[r].ppo));
      end

      // Free-run 17 fetches: PC wraps 15 -> 0
      tick(0, 0, 0, 4'd0, "wrap.rst");
      for (int k = 1; k <= 17; k++) begin
         tick(1, 0, 0, 4'd0, "wrap");
         chk($sformatf("wrap.pc%0d", k), 64'(outPcAddr), 64'(k % 16));
      end
      chk("wrap.count17", 64'(outFetchCount), 64'd17);

      // Stall at PC=5 for three cycles, then resume without a bubble
      tick(0, 0, 0, 4'd0, "stall.rst");
      for (int k = 0; k < 5; k++) tick(1, 0, 0, 4'd0, "stall.pre");
      for (int k = 0; k < 3; k++) begin
         tick(1, 1, 0, 4'd0, "stall");
         chk("stall.pc", 64'(outPcAddr), 64'd5);
         chk("stall.instr", 64'(outInstructionIfId), 64'(mem[4]));
         chk("stall.valid", 64'(outValid), 64'd1);
         chk("stall.count", 64'(outFetchCount), 64'd5);
      end
      tick(1, 0, 0, 4'd0, "stall.rel");
      chk("stall.rel.instr", 64'(outInstructionIfId), 64'(mem[5]));

      // Branch with simultaneous stall at PC=7 -> target 2
      tick(1, 0, 0, 4'd0, "br.pre");
      chk("br.pre.pc", 64'(outPcAddr), 64'd7);
      tick(1, 1, 1, 4'd2, "br");
      chk("br.pc", 64'(outPcAddr), 64'd2);
      chk("br.valid", 64'(outValid), 64'd0);
      chk("br.instr", 64'(outInstructionIfId), 64'd0);
      tick(1, 0, 0, 4'd0, "br.post");
      chk("br.post.instr", 64'(outInstructionIfId), 64'(mem[2]));
      chk("br.post.ppo", 64'(outPcPlusOneIfId), 64'd3);
      chk("br.post.valid", 64'(outValid), 64'd1);

      // All-ones word at address 8
      mem[8] = 32'hFFFF_FFFF;
      tick(0, 0, 0, 4'd0, "halt.rst");
      for (int k = 0; k < 9; k++) tick(1, 0, 0, 4'd0, "halt.pre");
      if (HaltEn) begin
         chk("halt.flag", 64'(outHalted), 64'd1);
         chk("halt.pc", 64'(outPcAddr), 64'd8);
         chk("halt.valid", 64'(outValid), 64'd0);
         chk("halt.count", 64'(outFetchCount), 64'd8);
      end else begin
         chk("nohalt.flag", 64'(outHalted), 64'd0);
         chk("nohalt.pc", 64'(outPcAddr), 64'd9);
         chk("nohalt.valid", 64'(outValid), 64'd1);
         chk("nohalt.instr", 64'(outInstructionIfId), 64'hFFFF_FFFF);
         chk("nohalt.count", 64'(outFetchCount), 64'd9);
      end
      tick(1, 1, 0, 4'd0, "halt.hold");
      tick(1, 0, 0, 4'd0, "halt.hold");
      tick(1, 0, 1, 4'd0, "halt.br");
      chk("halt.br.flag", 64'(outHalted), 64'd0);
      chk("halt.br.pc", 64'(outPcAddr), 64'd0);
      tick(1, 0, 0, 4'd0, "halt.resume");
      chk("halt.resume.instr", 64'(outInstructionIfId), 64'(mem[0]));
      chk("halt.resume.valid", 64'(outValid), 64'd1);
      mem[8] = 32'hA000_0008;

      // Reset asserted mid-stall at PC=12
      tick(0, 0, 0, 4'd0, "rststall.rst");
      for (int k = 0; k < 12; k++) tick(1, 0, 0, 4'd0, "rststall.pre");
      tick(1, 1, 0, 4'd0, "rststall.stall");
      chk("rststall.pc12", 64'(outPcAddr), 64'd12);
      tick(0, 1, 0, 4'd0, "rststall.rst2");
      chk("rststall.zero", {outPcAddr, outInstructionIfId, outPcPlusOneIfId, outValid,
                            outHalted, outFetchCount}, 64'd0);
      tick(1, 0, 0, 4'd0, "rststall.restart");
      chk("rststall.restart.instr", 64'(outInstructionIfId), 64'(mem[0]));
      chk("rststall.restart.pc", 64'(outPcAddr), 64'd1);

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         if (c % 64 == 0) begin
            for (int i = 0; i < 16; i++)
               mem[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         end
         tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_ctrl.md
# instruction_fetch_ctrl

Sequences the 16-word instruction memory. It holds the program counter and drives the read address. It captures the returned word into the IF/ID pipeline register and handles stalls, branch redirects with flush, and an optional halt. It sits between the instruction memory (combinational read) and the decode stage of the pipeline.

## Interface

Parameters:
- ADDR_W, 4, program counter / memory address width; memory depth is 2^ADDR_W
- DATA_W, 32, instruction width
- CNT_W, 16, width of the fetched-instruction counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge)
- inStall  input  1  hold PC and IF/ID register
- inBranchTaken  input  1  redirect request from a later stage (registered there)
- inBranchTarget  input  ADDR_W  redirect address
- inInstruction  input  DATA_W  combinational read data from instruction memory
- outPcAddr  output  ADDR_W  read address to instruction memory (equals PC)
- outInstructionIfId  output  DATA_W  IF/ID instruction
- outPcPlusOneIfId  output  ADDR_W  IF/ID PC+1 of the captured instruction
- outValid  output  1  IF/ID holds a real instruction
- outHalted  output  1  fetch halted (0 when FETCH_HALT_EN absent)
- outFetchCount  output  CNT_W  number of instructions delivered, saturating

## Operation

- Registers:
  - PC
  - IF/ID {instruction, pcPlusOne, valid}
  - halted
  - fetch counter
- outPcAddr = PC, combinational from the register, no other logic.
- Priority per cycle, highest first: reset, branch, halted, stall, normal.
- **Reset (reset==0):**
  - PC=0, IF/ID instruction=0, pcPlusOne=0, valid=0, halted=0, count=0.
  - All outputs are 0 in the cycle after reset.
- **Branch (inBranchTaken=1):**
  - PC=inBranchTarget.
  - IF/ID instruction=0 (NOP), valid=0; the wrong-path word is flushed.
  - Overrides inStall and halted; it clears halted.
  - Count does not increment.
- **Halted:** PC and count are frozen; valid=0, instruction=0.
- **Stall (inStall=1, no branch):** PC and the whole IF/ID register are held unchanged, including valid.
- **Normal:**
  - IF/ID = {inInstruction, PC+1}, valid=1.
  - PC = PC+1, modulo 2^ADDR_W (15 wraps to 0 with no flag).
  - count = count+1, saturating at 2^CNT_W-1.
- Arithmetic: PC+1 is truncated to ADDR_W bits; the counter never wraps.

## Timing

- Address-to-capture latency: 1 cycle. The word at PC on edge N is visible on outInstructionIfId after edge N.
- First instruction after reset release: memory[0] appears with valid=1 one cycle after the first edge with reset==1.
- Branch penalty: 1 bubble (valid=0 for one cycle). The target word appears the cycle after that.
- Stall deassertion resumes with no bubble; the held word stays valid throughout the stall.
- Simultaneous inBranchTaken and inStall: the branch wins, PC is redirected, and IF/ID is flushed.
- Reset mid-stream, including mid-stall or mid-branch: it takes effect on that edge and discards all state.

## Configuration

- Macro: FETCH_HALT_EN.
- **Defined:**
  - In the normal case, a captured inInstruction equal to all ones (32'hFFFFFFFF) sets halted on that same edge.
  - That word is loaded with valid=0 and is not counted, and PC is not advanced.
  - Halted persists until reset or a branch.
- **Undefined:**
  - All-ones is an ordinary instruction: captured valid, counted, PC advanced.
  - outHalted is tied to 0.

## Test plan

- Reset low 3 cycles, then release with memory[0]=32'h10010001, memory[1]=32'h8CC30000 -> after edge 1: IF/ID=32'h10010001, pcPlusOne=1, valid=1, count=1; after edge 2: 32'h8CC30000, count=2.
- Free-run 17 cycles from reset -> PC sequence 0..15,0; outPcAddr wraps to 0 with no glitch; count=17.
- At PC=5, assert inStall for 3 cycles -> PC stays 5; IF/ID holds the word from address 4 with valid=1; count unchanged; release -> word 5 captured next edge.
- At PC=7, pulse inBranchTaken with target 2 and inStall=1 simultaneously -> PC=2, valid=0, instruction=0 for one cycle, then memory[2] captured with pcPlusOne=3.
- FETCH_HALT_EN defined, memory[8]=32'hFFFFFFFF -> after fetching address 8: outHalted=1, PC=8, valid=0, count frozen; a branch to 0 clears halted and fetch resumes; with the macro undefined, the same word is captured valid and PC goes to 9.
- Assert reset mid-stall at PC=12 -> next edge: all outputs 0; fetch restarts at address 0.
